// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared encodings for the multiply/divide sequencing
//                controller: FSM states, operation select and completion
//                cause codes.
//  Revision    : 1.0  initial release
// ============================================================================
package md_pkg;

    // FSM state encoding
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_LAUNCH = S_LAUNCH,
        ST_WAIT   = S_WAIT,
        ST_DONE   = S_DONE
    } md_state_t;

    // Operation select as driven by the control unit on MDControl
    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    // Why the controller went to DONE; selects the pulse emitted there
    typedef enum logic [1:0] {
        CAUSE_OK      = 2'd0,
        CAUSE_TIMEOUT = 2'd1,
        CAUSE_DIV0    = 2'd2
    } md_cause_t;

endpackage : md_pkg
`default_nettype wire

// File: rtl/md_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : md_watchdog
//  Description : Saturating cycle counter guarding the WAIT state. Cleared
//                on request accept, counts while enabled, and flags expiry
//                once it has reached TIMEOUT-1.
//  Revision    : 1.0  initial release
// ============================================================================
module md_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int               c_cnt_w = $clog2(TIMEOUT) + 1;
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_count;

    // Count enabled cycles, holding at the limit so expiry stays asserted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != c_limit)) begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    assign expired = (r_count == c_limit);

endmodule : md_watchdog
`default_nettype wire

// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : md_ctrl
//  Description : Sequencer for the shared iterative multiplier/divider.
//                Accepts one request in IDLE, launches the selected unit,
//                waits for its done (bounded by a watchdog) and commits the
//                result into HI/LO. Optional feature macro:
//                MD_DIV0_DETECT_EN - short-circuit divide by zero to md_div0.
//  Revision    : 1.0  initial release
// ============================================================================
module md_ctrl
    import md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_start,
    input  logic             MDControl,
    input  logic [WIDTH-1:0] md_a,
    input  logic [WIDTH-1:0] md_b,
    output logic             md_busy,
    output logic             md_done,
    output logic             md_timeout,
    output logic             md_div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             mult_start,
    output logic             div_start,
    input  logic             mult_done,
    input  logic             div_done,
    input  logic [WIDTH-1:0] mult_hi,
    input  logic [WIDTH-1:0] mult_lo,
    input  logic [WIDTH-1:0] div_quot,
    input  logic [WIDTH-1:0] div_rem
);

    md_state_t r_state;
    md_state_t w_next;
    md_cause_t r_cause;
    md_cause_t w_cause_next;
    logic      r_op;
    logic      w_accept;
    logic      w_commit;
    logic      w_wd_en;
    logic      w_wd_expired;
    logic      w_unit_done;
    logic      w_div0_req;

    // Only the launched unit's done is of interest
    assign w_unit_done = (r_op == MD_OP_DIV) ? div_done : mult_done;

`ifdef MD_DIV0_DETECT_EN
    assign w_div0_req = (MDControl == MD_OP_DIV) && (md_b == '0);
`else
    assign w_div0_req = 1'b0;
`endif

    md_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_accept),
        .en      (w_wd_en),
        .expired (w_wd_expired)
    );

    // State and completion-cause registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cause <= CAUSE_OK;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause_next;
        end
    end

    // Next-state decode and all handshake/status outputs
    always_comb begin
        w_next       = r_state;
        w_cause_next = r_cause;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        w_wd_en      = 1'b0;
        mult_start   = 1'b0;
        div_start    = 1'b0;
        md_done      = 1'b0;
        md_timeout   = 1'b0;
        md_div0      = 1'b0;
        md_busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (md_start) begin
                    w_accept = 1'b1;
                    if (w_div0_req) begin
                        w_next       = ST_DONE;
                        w_cause_next = CAUSE_DIV0;
                    end else begin
                        w_next = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                mult_start = (r_op == MD_OP_MULT);
                div_start  = (r_op == MD_OP_DIV);
                w_next     = ST_WAIT;
            end
            ST_WAIT: begin
                w_wd_en = 1'b1;
                // A done arriving on the expiry edge still commits
                if (w_unit_done) begin
                    w_commit     = 1'b1;
                    w_next       = ST_DONE;
                    w_cause_next = CAUSE_OK;
                end else if (w_wd_expired) begin
                    w_next       = ST_DONE;
                    w_cause_next = CAUSE_TIMEOUT;
                end
            end
            ST_DONE: begin
                md_done    = (r_cause == CAUSE_OK);
                md_timeout = (r_cause == CAUSE_TIMEOUT);
`ifdef MD_DIV0_DETECT_EN
                md_div0    = (r_cause == CAUSE_DIV0);
`endif
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand latch on accept and HI/LO commit on unit completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a <= '0;
            op_b <= '0;
            r_op <= MD_OP_MULT;
            hi   <= '0;
            lo   <= '0;
        end else begin
            if (w_accept) begin
                op_a <= md_a;
                op_b <= md_b;
                r_op <= MDControl;
            end
            if (w_commit) begin
                if (r_op == MD_OP_DIV) begin
                    lo <= div_quot;
                    hi <= div_rem;
                end else begin
                    hi <= mult_hi;
                    lo <= mult_lo;
                end
            end
        end
    end

endmodule : md_ctrl
`default_nettype wire

// File: tb/tb_md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_ctrl
//  Description : Self-checking bench for md_ctrl. The bench plays the role
//                of both iterative units and of the control unit, and keeps
//                its own HI/LO and cycle-timeline model of each request.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_md_ctrl;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             md_start;
    logic             MDControl;
    logic [WIDTH-1:0] md_a;
    logic [WIDTH-1:0] md_b;
    logic             md_busy;
    logic             md_done;
    logic             md_timeout;
    logic             md_div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             mult_start;
    logic             div_start;
    logic             mult_done;
    logic             div_done;
    logic [WIDTH-1:0] mult_hi;
    logic [WIDTH-1:0] mult_lo;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [WIDTH-1:0] exp_hi  = '0;
    logic [WIDTH-1:0] exp_lo  = '0;

    always #5 clk = ~clk;

    md_ctrl #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .md_start   (md_start),
        .MDControl  (MDControl),
        .md_a       (md_a),
        .md_b       (md_b),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .md_timeout (md_timeout),
        .md_div0    (md_div0),
        .hi         (hi),
        .lo         (lo),
        .op_a       (op_a),
        .op_b       (op_b),
        .mult_start (mult_start),
        .div_start  (div_start),
        .mult_done  (mult_done),
        .div_done   (div_done),
        .mult_hi    (mult_hi),
        .mult_lo    (mult_lo),
        .div_quot   (div_quot),
        .div_rem    (div_rem)
    );

    // {mult_start, div_start, md_done, md_timeout, md_div0, md_busy}
    function automatic logic [5:0] flags();
        return {mult_start, div_start, md_done, md_timeout, md_div0, md_busy};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one unit's done and result buses for the next edge
    task automatic drive_unit(input logic sel_div, input logic [WIDTH-1:0] v1, input logic [WIDTH-1:0] v2);
        if (sel_div) begin
            div_done = 1'b1;
            div_quot = v1;
            div_rem  = v2;
        end else begin
            mult_done = 1'b1;
            mult_hi   = v1;
            mult_lo   = v2;
        end
    endtask

    // Idle cycles with stray unit dones that must be ignored
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            check("idle_flags", 64'(flags()), 64'h0);
            check("idle_hi", 64'(hi), 64'(exp_hi));
            check("idle_lo", 64'(lo), 64'(exp_lo));
            mult_done = 1'b0;
            div_done  = 1'b0;
            if ($urandom_range(0, 1) == 1)
                drive_unit(1'($urandom), $urandom, $urandom);
            @(negedge clk);
        end
        mult_done = 1'b0;
        div_done  = 1'b0;
    endtask

    // One request, observed every cycle from the accept edge to return to IDLE.
    // Called at a falling edge with the DUT in IDLE. k = cycles after the
    // launch cycle at which the unit raises done; hang = unit never answers;
    // poke = spurious request during WAIT; b2b = request held over DONE exit.
    task automatic run_op(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int k, input bit hang, input bit poke, input bit b2b);
        logic [2*WIDTH-1:0] prod;
        logic [WIDTH-1:0]   r1, r2, nh, nl;
        logic [5:0]         ef;
        bit                 div0, hng, commit;
        int                 last;
        div0 = 1'b0;
`ifdef MD_DIV0_DETECT_EN
        div0 = (op == 1'b1) && (b == '0);
`endif
        hng = hang && !div0;
        // Unit answers: mult gives {hi,lo}; div gives quot/rem (arbitrary for b==0)
        if (op == 1'b0) begin
            prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
            r1 = prod[2*WIDTH-1:WIDTH];
            r2 = prod[WIDTH-1:0];
            nh = r1;
            nl = r2;
        end else begin
            if (b != '0) begin
                r1 = a / b;
                r2 = a % b;
            end else begin
                r1 = '1;
                r2 = a;
            end
            nl = r1;
            nh = r2;
        end
        commit = !div0 && !hng;
        last   = div0 ? 0 : (hng ? TIMEOUT + 1 : k + 1);

        md_start  = 1'b1;
        MDControl = op;
        md_a      = a;
        md_b      = b;
        @(negedge clk);
        md_start  = 1'b0;
        MDControl = 1'($urandom);
        md_a      = $urandom;
        md_b      = $urandom;
        for (int c = 0; c <= last; c++) begin
            ef = {(!div0 && c == 0 && op == 1'b0), (!div0 && c == 0 && op == 1'b1),
                  (c == last && commit), (c == last && hng), (c == last && div0), 1'b1};
            check("flags", 64'(flags()), 64'(ef));
            check("hi", 64'(hi), 64'((c == last && commit) ? nh : exp_hi));
            check("lo", 64'(lo), 64'((c == last && commit) ? nl : exp_lo));
            check("op_a", 64'(op_a), 64'(a));
            check("op_b", 64'(op_b), 64'(b));
            mult_done = 1'b0;
            div_done  = 1'b0;
            md_start  = 1'b0;
            if (!div0 && c == 0 && $urandom_range(0, 1) == 1)
                drive_unit(op, $urandom, $urandom);
            if (!div0 && c >= 1 && c < last && $urandom_range(0, 3) == 0)
                drive_unit(!op, $urandom, $urandom);
            if (!div0 && !hng && c == k)
                drive_unit(op, r1, r2);
            if (poke && !div0 && c == 1) begin
                md_start  = 1'b1;
                MDControl = 1'($urandom);
                md_a      = $urandom;
                md_b      = $urandom;
            end
            if (b2b && c == last) begin
                md_start = 1'b1;
                md_a     = $urandom;
                md_b     = $urandom;
            end
            @(negedge clk);
        end
        if (commit) begin
            exp_hi = nh;
            exp_lo = nl;
        end
        mult_done = 1'b0;
        div_done  = 1'b0;
        check("post_flags", 64'(flags()), 64'h0);
        check("post_op_a", 64'(op_a), 64'(a));
        md_start = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        md_start  = 1'b0;
        MDControl = 1'b0;
        md_a      = '0;
        md_b      = '0;
        mult_done = 1'b0;
        div_done  = 1'b0;
        mult_hi   = '0;
        mult_lo   = '0;
        div_quot  = '0;
        div_rem   = '0;
        @(negedge clk);
        check("rst_flags", 64'(flags()), 64'h0);
        check("rst_hilo", {32'(hi), 32'(lo)}, 64'h0);
        check("rst_ops", {32'(op_a), 32'(op_b)}, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        idle_cycles(2);

        // Directed scenarios
        run_op(1'b0, 32'd10, 32'd2, 33, 1'b0, 1'b0, 1'b0);
        check("mult_10x2_lo", 64'(lo), 64'd20);
        idle_cycles(1);
        run_op(1'b1, 32'd100, 32'd5, 7, 1'b0, 1'b0, 1'b0);
        check("div_100_5", {32'(hi), 32'(lo)}, {32'd0, 32'd20});
        idle_cycles(1);
        run_op(1'b1, 32'd7, 32'd0, 3, 1'b0, 1'b0, 1'b0);
        idle_cycles(1);
        run_op(1'b0, 32'd9, 32'd11, 12, 1'b0, 1'b1, 1'b0);
        run_op(1'b0, 32'd5, 32'd5, 1, 1'b0, 1'b0, 1'b1);
        run_op(1'b1, 32'd1000, 32'd7, TIMEOUT, 1'b0, 1'b0, 1'b0);
        run_op(1'b0, 32'hdead_beef, 32'h1234_5678, 4, 1'b1, 1'b0, 1'b0);
        idle_cycles(1);

        // Asynchronous reset in the middle of WAIT
        md_start  = 1'b1;
        MDControl = 1'b0;
        md_a      = 32'd1234;
        md_b      = 32'd5678;
        @(negedge clk);
        md_start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_flags", 64'(flags()), 64'h0);
        check("arst_hilo", {32'(hi), 32'(lo)}, 64'h0);
        check("arst_ops", {32'(op_a), 32'(op_b)}, 64'h0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        idle_cycles(2);
        run_op(1'b0, 32'd6, 32'd7, 5, 1'b0, 1'b0, 1'b0);
        check("mult_6x7_lo", 64'(lo), 64'd42);

        // Randomized requests
        for (int n = 0; n < 30; n++) begin
            logic             op;
            logic [WIDTH-1:0] a, b;
            int               k;
            op = 1'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? '0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
            k  = ($urandom_range(0, 5) == 0) ? TIMEOUT : $urandom_range(1, 40);
            run_op(op, a, b, k, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1)
                idle_cycles($urandom_range(1, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_md_ctrl
`default_nettype wire
